// File: rtl/sequential_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results hold in DONE until the next accepted start or reset.
module sequential_divider #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             divByZero,
   output logic             quotientDone
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH-1:0] dq;
   logic [WIDTH:0]   prem;
   logic [CW-1:0]    cnt;
   logic             dbz;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Shift {prem, dq} left by one; the dividend MSB enters the remainder LSB.
   always_comb begin
      shifted = (prem << 1) | {{WIDTH{1'b0}}, dq[WIDTH-1]};
      trial   = shifted - {1'b0, dvsr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dvsr  <= '0;
         dq    <= '0;
         prem  <= '0;
         cnt   <= '0;
         dbz   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  dvsr  <= divisor;
                  dq    <= dividend;
                  prem  <= '0;
                  cnt   <= '0;
                  dbz   <= (divisor == '0);
                  state <= RUN;
               end
            end
            RUN: begin
               if (!trial[WIDTH]) begin
                  prem <= trial;
                  dq   <= {dq[WIDTH-2:0], 1'b1};
               end else begin
                  prem <= shifted;
                  dq   <= {dq[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign quotient     = dq;
   assign remainder    = prem[WIDTH-1:0];
   assign divByZero    = dbz;
   assign quotientDone = (state == DONE);

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider at WIDTH=8: directed handshake/edge cases
// followed by random operands checked against a plain-arithmetic reference.
module tb_sequential_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         divByZero;
   logic         quotientDone;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   sequential_divider #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dividend     (dividend),
      .divisor      (divisor),
      .quotient     (quotient),
      .remainder    (remainder),
      .divByZero    (divByZero),
      .quotientDone (quotientDone)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Present operands with start for one edge; returns at the negedge after the accepting edge.
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start    = 1'b0;
      dividend = ~a;
      divisor  = ~b;
      cyc      = 0;
      chk("done_low_after_accept", {63'd0, quotientDone}, 64'd0);
   endtask

   task automatic wait_done();
      while (!quotientDone && cyc < 4 * W) step();
      chk("latency", 64'(cyc), 64'(W));
      chk("done_high", {63'd0, quotientDone}, 64'd1);
   endtask

   task automatic expect_res(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz);
      chk({tag, "_q"}, 64'(quotient), 64'(eq));
      chk({tag, "_r"}, 64'(remainder), 64'(er));
      chk({tag, "_dbz"}, {63'd0, divByZero}, {63'd0, edbz});
   endtask

   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
      launch(a, b);
      wait_done();
      expect_res(tag, eq, er, edbz);
   endtask

   initial begin
      logic [W-1:0]   a, b, mq, mr;
      logic [2*W-1:0] recon;

      rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("rst_done", {63'd0, quotientDone}, 64'd0);
      expect_res("rst", 8'd0, 8'd0, 1'b0);
      rst = 1'b0;

      // Basic division with hold check
      run_div("basic", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
      repeat (5) step();
      chk("hold_done", {63'd0, quotientDone}, 64'd1);
      expect_res("hold", 8'd14, 8'd2, 1'b0);

      run_div("e255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
      run_div("e5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
      run_div("e0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
      run_div("e255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
      run_div("dbz", 8'd77, 8'd0, 8'd255, 8'd77, 1'b1);
      run_div("after_dbz", 8'd77, 8'd7, 8'd11, 8'd0, 1'b0);

      // Start during RUN is ignored
      launch(8'd100, 8'd7);
      repeat (3) step();
      start = 1'b1; dividend = 8'd9; divisor = 8'd2;
      step();
      start = 1'b0;
      wait_done();
      expect_res("run_ignore", 8'd14, 8'd2, 1'b0);

      // Start accepted directly from DONE
      run_div("from_done", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0);

      // Reset during iteration 4 aborts
      launch(8'd100, 8'd7);
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_done", {63'd0, quotientDone}, 64'd0);
      expect_res("abort", 8'd0, 8'd0, 1'b0);
      repeat (12) step();
      chk("abort_idle", {63'd0, quotientDone}, 64'd0);
      run_div("post_abort", 8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

      // Reset wins over start on the same edge
      @(negedge clk);
      rst = 1'b1; start = 1'b1; dividend = 8'd40; divisor = 8'd3;
      step();
      rst = 1'b0; start = 1'b0;
      repeat (12) step();
      chk("rst_start_idle", {63'd0, quotientDone}, 64'd0);
      expect_res("rst_start", 8'd0, 8'd0, 1'b0);

      // Random operands against the arithmetic reference
      for (int n = 0; n < 1500; n++) begin
         a = W'($urandom);
         case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2:    b = W'($urandom_range(1, 15));
            default: b = W'($urandom);
         endcase
         if (b == '0) begin
            mq = '1;
            mr = a;
         end else begin
            mq = a / b;
            mr = a % b;
         end
         run_div("rnd", a, b, mq, mr, (b == '0));
         if (b != '0) begin
            recon = quotient * b + (2*W)'(remainder);
            chk("rnd_ident", 64'(recon), 64'(a));
            chk("rnd_r_lt_d", {63'd0, (remainder < b)}, 64'd1);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
